// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised modulo up/down counter with synchronous load,
// clock-enable prescaler, wrap or saturate at the bounds, a terminal-count pulse
// and a sticky overflow flag.
//
// Ports
//   clk       in   1      clock, rising edge
//   reset     in   1      synchronous, active-low reset
//   en        in   1      count enable; gates prescaler and stepping
//   dir       in   1      0 = count up, 1 = count down
//   load      in   1      synchronous load strobe (ignores en)
//   load_val  in   WIDTH  value loaded on load, clamped to MAX_VAL
//   clr_ovf   in   1      clears sticky ovf (a same-cycle bound event wins)
//   count     out  WIDTH  current count (registered)
//   tc        out  1      one-cycle pulse after a step taken at a bound (registered)
//   ovf       out  1      sticky bound-event flag (registered)
//   zero      out  1      combinational, count == 0
module mod_updown_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step_c;
  logic             bound_c;

  // Next-state: load beats stepping; a step at a bound raises tc and ovf.
  always_comb begin
    count_d = count_q;
    ps_d    = ps_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    step_c  = 1'b0;
    bound_c = 1'b0;

    if (load) begin
      count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      ps_d    = '0;
      if (clr_ovf) begin
        ovf_d = 1'b0;
      end
    end else begin
      if (en) begin
        if (ps_q == PS_LAST) begin
          ps_d   = '0;
          step_c = 1'b1;
        end else begin
          ps_d = ps_q + PS_W'(1);
        end
      end

      if (step_c) begin
        if (!dir) begin
          if (count_q == MAX_VAL) begin
            bound_c = 1'b1;
            count_d = SATURATE ? MAX_VAL : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            bound_c = 1'b1;
            count_d = SATURATE ? '0 : MAX_VAL;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end

      tc_d = bound_c;
      // Set wins over a simultaneous clear.
      if (bound_c) begin
        ovf_d = 1'b1;
      end else if (clr_ovf) begin
        ovf_d = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
      ps_q    <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ps_q    <= ps_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Testbench for mod_updown_counter: four configurations share one stimulus
// stream; a reference model pushes expected outputs into a scoreboard queue
// and a monitor pops and compares after every rising edge.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       clr_ovf = 1'b0;

  logic [3:0] cnt0, cnt1, cnt2;
  logic [2:0] cnt3;
  logic [3:0] tc_o, ovf_o, zero_o;

  always #5 clk = ~clk;

  // cfg0: 0..9 wrap, step every cycle
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(1'b0)) u0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt0), .tc(tc_o[0]), .ovf(ovf_o[0]), .zero(zero_o[0]));
  // cfg1: 0..9 wrap, step every 3rd enabled cycle
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(3), .SATURATE(1'b0)) u1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt1), .tc(tc_o[1]), .ovf(ovf_o[1]), .zero(zero_o[1]));
  // cfg2: 0..9 saturate
  mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .PRESCALE(1), .SATURATE(1'b1)) u2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .clr_ovf(clr_ovf), .count(cnt2), .tc(tc_o[2]), .ovf(ovf_o[2]), .zero(zero_o[2]));
  // cfg3: default full range 0..7, wrap, step every 2nd enabled cycle
  mod_updown_counter #(.WIDTH(3), .PRESCALE(2)) u3 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val[2:0]),
    .clr_ovf(clr_ovf), .count(cnt3), .tc(tc_o[3]), .ovf(ovf_o[3]), .zero(zero_o[3]));

  typedef struct packed {
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       zero;
  } exp_t;
  typedef exp_t [3:0] exp4_t;

  exp4_t sbq[$];

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  bit stim_done = 1'b0;

  // Reference model state, one slot per configuration.
  int cfg_max[4]  = '{9, 9, 9, 7};
  int cfg_pre[4]  = '{1, 3, 1, 2};
  bit cfg_sat[4]  = '{0, 0, 1, 0};
  int cfg_mask[4] = '{15, 15, 15, 7};
  int m_cnt[4];
  int m_ps[4];
  bit m_ovf[4];

  // Advance the model one clock and return what each DUT should show after it.
  task automatic model_cycle(input bit r, input bit ld, input logic [3:0] lv,
                             input bit e, input bit d, input bit c, output exp4_t ex);
    for (int i = 0; i < 4; i++) begin
      int mx;
      int v;
      bit t;
      bit hit;
      mx = cfg_max[i];
      t  = 1'b0;
      if (!r) begin
        m_cnt[i] = 0;
        m_ps[i]  = 0;
        m_ovf[i] = 1'b0;
      end else if (ld) begin
        v = int'(lv) & cfg_mask[i];
        m_cnt[i] = (v > mx) ? mx : v;
        m_ps[i]  = 0;
        if (c) m_ovf[i] = 1'b0;
      end else begin
        if (e) begin
          m_ps[i] = m_ps[i] + 1;
          if (m_ps[i] == cfg_pre[i]) begin
            m_ps[i] = 0;
            hit = d ? (m_cnt[i] == 0) : (m_cnt[i] == mx);
            if (!(hit && cfg_sat[i]))
              m_cnt[i] = d ? (m_cnt[i] + mx) % (mx + 1) : (m_cnt[i] + 1) % (mx + 1);
            t = hit;
          end
        end
        if (t) m_ovf[i] = 1'b1;
        else if (c) m_ovf[i] = 1'b0;
      end
      ex[i].cnt  = 4'(m_cnt[i]);
      ex[i].tc   = t;
      ex[i].ovf  = m_ovf[i];
      ex[i].zero = (m_cnt[i] == 0);
    end
  endtask

  // Drive one cycle of inputs and push the expected response.
  task automatic cyc(input bit r, input bit ld, input logic [3:0] lv,
                     input bit e, input bit d, input bit c);
    exp4_t ex;
    @(negedge clk);
    reset    = r;
    load     = ld;
    load_val = lv;
    en       = e;
    dir      = d;
    clr_ovf  = c;
    model_cycle(r, ld, lv, e, d, c, ex);
    sbq.push_back(ex);
  endtask

  // Monitor: after each rising edge, compare DUT outputs with the oldest entry.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        exp4_t ex;
        exp4_t got;
        ex = sbq.pop_front();
        got[0] = {cnt0, tc_o[0], ovf_o[0], zero_o[0]};
        got[1] = {cnt1, tc_o[1], ovf_o[1], zero_o[1]};
        got[2] = {cnt2, tc_o[2], ovf_o[2], zero_o[2]};
        got[3] = {1'b0, cnt3, tc_o[3], ovf_o[3], zero_o[3]};
        for (int i = 0; i < 4; i++) begin
          total++;
          if (got[i] !== ex[i]) begin
            bad++;
            $display("FAIL cfg%0d cyc%0d: got cnt=%0d tc=%0b ovf=%0b zero=%0b, required cnt=%0d tc=%0b ovf=%0b zero=%0b",
                     i, cyc_n, got[i].cnt, got[i].tc, got[i].ovf, got[i].zero,
                     ex[i].cnt, ex[i].tc, ex[i].ovf, ex[i].zero);
          end
        end
        cyc_n++;
      end
    end
  end

  // Stimulus: directed scenarios followed by a random stream.
  initial begin
    bit d;
    cyc(0, 0, 4'd0, 0, 0, 0);
    cyc(0, 0, 4'd0, 1, 0, 0);
    // count up through the wrap
    for (int k = 0; k < 12; k++) cyc(1, 0, 4'd0, 1, 0, 0);
    // count down through zero
    for (int k = 0; k < 4; k++) cyc(1, 0, 4'd0, 1, 1, 0);
    // clear ovf while idle
    cyc(1, 0, 4'd0, 0, 0, 1);
    cyc(1, 0, 4'd0, 0, 0, 0);
    // clear ovf together with a wrap at zero
    cyc(1, 1, 4'd0, 0, 0, 1);
    cyc(1, 0, 4'd0, 1, 1, 1);
    cyc(1, 0, 4'd0, 1, 1, 0);
    // load 8 then up through the upper bound
    cyc(1, 1, 4'd8, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 4'd0, 1, 0, 0);
    // clamped load, then load 0 and step down at the lower bound
    cyc(1, 1, 4'd15, 1, 0, 0);
    cyc(1, 0, 4'd0, 0, 0, 0);
    cyc(1, 1, 4'd0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 4'd0, 1, 1, 0);
    // prescale with en dropped mid-period and a dir change mid-period
    cyc(1, 1, 4'd2, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 0, 4'd0, 1, 0, 0);
    for (int k = 0; k < 2; k++) cyc(1, 0, 4'd0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(1, 0, 4'd0, 1, 0, 0);
    cyc(1, 0, 4'd0, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(1, 0, 4'd0, 1, 1, 0);
    // load with en=1 at count 5, then reset with tc pending
    cyc(1, 1, 4'd5, 1, 0, 0);
    cyc(1, 1, 4'd3, 1, 0, 0);
    cyc(1, 1, 4'd9, 1, 0, 0);
    cyc(1, 0, 4'd0, 1, 0, 0);
    cyc(0, 0, 4'd0, 1, 0, 0);
    cyc(1, 0, 4'd0, 1, 0, 0);
    // random stream
    d = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(7) == 0) d = ~d;
      cyc($urandom_range(63) != 0, $urandom_range(15) == 0, 4'($urandom_range(15)),
          $urandom_range(3) != 0, d, $urandom_range(15) == 0);
    end
    @(posedge clk);
    #3;
    stim_done = 1'b1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d entries left, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case the clock or stimulus ever stalls.
  initial begin
    #500000;
    if (!stim_done) begin
      $display("FAIL timeout: got no completion, required completion by 500000");
      $fatal(1, "timeout");
    end
  end

endmodule
